// File: rtl/lbp_engine.sv
// Local Binary Pattern engine: scans the interior of a grayscale image through a
// sliding 3x3 window and writes one 8-bit LBP code per interior pixel, optionally
// followed by zero codes for every border address.
module lbp_engine #(
  parameter int unsigned IMG_W       = 8,
  parameter int unsigned IMG_H       = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned BORDER_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] thr,
  output logic              busy,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic [DATA_W-1:0] gray_data,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              lbp_write,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  localparam logic [XW-1:0] XLast = XW'(IMG_W - 2);  // last interior column
  localparam logic [XW-1:0] XMax  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 2);  // last interior row
  localparam logic [YW-1:0] YMax  = YW'(IMG_H - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StLast,
    StWrite,
    StShift,
    StBorder,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Pixel / border scan position
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  // Window row/column of the read being issued this cycle
  logic [1:0]    r_q, r_d;
  logic [1:0]    c_q, c_d;
  // Window slot whose datum arrives on gray_data this cycle
  logic          cap_v_q;
  logic [1:0]    cap_r_q, cap_c_q;

  logic              mode_q, mode_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] gaddr_q, laddr_q;

  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_m [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic              shift_win;

  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] thr_eff;
  logic [DATA_W:0]   limit;
  logic [DATA_W-1:0] nbr [8];
  logic [7:0]        code;

  // Address generation for the current read and write positions
  always_comb begin
    rd_addr = ADDR_W'((int'(y_q) + int'(r_q) - 1) * int'(IMG_W) + int'(x_q) + int'(c_q) - 1);
    wr_addr = ADDR_W'(int'(y_q) * int'(IMG_W) + int'(x_q));
  end

  // Window as it will be after this cycle's capture, then the code it yields
  always_comb begin
    win_m = win_q;
    if (cap_v_q) begin
      win_m[cap_r_q][cap_c_q] = gray_data;
    end
    thr_eff = mode_q ? thr_q : '0;
    // One extra bit so center+thr never wraps; a saturated limit clears the bit
    limit   = {1'b0, win_m[1][1]} + {1'b0, thr_eff};
    nbr[0]  = win_m[0][0];
    nbr[1]  = win_m[0][1];
    nbr[2]  = win_m[0][2];
    nbr[3]  = win_m[1][0];
    nbr[4]  = win_m[1][2];
    nbr[5]  = win_m[2][0];
    nbr[6]  = win_m[2][1];
    nbr[7]  = win_m[2][2];
    code    = '0;
    for (int i = 0; i < 8; i++) begin
      code[i] = ({1'b0, nbr[i]} >= limit);
    end
  end

  // Next window: capture, or slide one column left before fetching a new right column
  always_comb begin
    win_d = win_m;
    if (shift_win) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
    end
  end

  // Next-state and scan-position logic
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    r_d       = r_q;
    c_d       = c_q;
    mode_d    = mode_q;
    thr_d     = thr_q;
    data_d    = data_q;
    shift_win = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          x_d     = XW'(1);
          y_d     = YW'(1);
          r_d     = 2'd0;
          c_d     = 2'd0;
          mode_d  = mode;
          thr_d   = thr;
        end
      end
      StFill: begin
        if (c_q == 2'd2) begin
          c_d = 2'd0;
          if (r_q == 2'd2) begin
            state_d = StLast;
          end else begin
            r_d = r_q + 2'd1;
          end
        end else begin
          c_d = c_q + 2'd1;
        end
      end
      StShift: begin
        if (r_q == 2'd2) begin
          state_d = StLast;
        end else begin
          r_d = r_q + 2'd1;
        end
      end
      StLast: begin
        state_d = StWrite;
        data_d  = code;
      end
      StWrite: begin
        if (x_q < XLast) begin
          state_d   = StShift;
          x_d       = x_q + XW'(1);
          r_d       = 2'd0;
          c_d       = 2'd2;
          shift_win = 1'b1;
        end else if (y_q < YLast) begin
          state_d = StFill;
          x_d     = XW'(1);
          y_d     = y_q + YW'(1);
          r_d     = 2'd0;
          c_d     = 2'd0;
        end else if (BORDER_MODE != 0) begin
          state_d = StBorder;
          x_d     = '0;
          y_d     = '0;
        end else begin
          state_d = StDone;
        end
      end
      StBorder: begin
        if (y_q == YMax && x_q == XMax) begin
          state_d = StDone;
        end else if (y_q == '0 || y_q == YMax) begin
          // Top and bottom rows are entirely border
          if (x_q == XMax) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end else if (x_q == '0) begin
          x_d = XMax;
        end else begin
          x_d = '0;
          y_d = y_q + YW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode; addresses hold their last value while the strobe is low
  always_comb begin
    busy      = (state_q != StIdle);
    finish    = (state_q == StDone);
    gray_req  = (state_q == StFill) || (state_q == StShift);
    lbp_write = (state_q == StWrite) || (state_q == StBorder);
    gray_addr = gray_req ? rd_addr : gaddr_q;
    lbp_addr  = lbp_write ? wr_addr : laddr_q;
    lbp_data  = (state_q == StBorder) ? 8'h00 : data_q;
  end

  // State, counters, window and held outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      cap_v_q <= 1'b0;
      cap_r_q <= '0;
      cap_c_q <= '0;
      mode_q  <= 1'b0;
      thr_q   <= '0;
      data_q  <= '0;
      gaddr_q <= '0;
      laddr_q <= '0;
      win_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cap_v_q <= gray_req;
      cap_r_q <= r_q;
      cap_c_q <= c_q;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      data_q  <= data_d;
      win_q   <= win_d;
      if (gray_req) begin
        gaddr_q <= rd_addr;
      end
      if (lbp_write) begin
        laddr_q <= wr_addr;
      end
    end
  end

endmodule

// File: tb/tb_lbp_engine.sv
// Directed bench for lbp_engine: three instances (8x8 plain, 8x8 with border fill,
// 5x4), a registered gray memory model and a write scoreboard fed by a reference model.
module tb_lbp_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, start, busy, greq, lw, fin;
  logic       mode;
  logic [7:0] thr;
  logic [5:0] ga0, ga1, la0, la1;
  logic [4:0] ga2, la2;
  logic [7:0] gd0, gd1, gd2, ld0, ld1, ld2;
  logic [7:0] la_x [3];
  logic [7:0] ld_x [3];

  logic [7:0]  img [64];
  logic [17:0] sb [$];  // {instance, addr, code}
  logic [17:0] e;

  int checks = 0, failures = 0, ec = 0, run_s = 0, cyc;
  int wr_cnt, req_cnt, fin_cnt, busy_cnt, first_req, first_wr, last_wr, fin_cyc;
  int first_busy, last_busy, overlap, first_wr_addr;
  logic [31:0] req_mask;

  lbp_engine #(.IMG_W(8), .IMG_H(8), .DATA_W(8), .ADDR_W(6), .BORDER_MODE(0)) u0 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .mode(mode), .thr(thr), .busy(busy[0]),
    .gray_addr(ga0), .gray_req(greq[0]), .gray_data(gd0), .lbp_addr(la0),
    .lbp_write(lw[0]), .lbp_data(ld0), .finish(fin[0])
  );
  lbp_engine #(.IMG_W(8), .IMG_H(8), .DATA_W(8), .ADDR_W(6), .BORDER_MODE(1)) u1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .mode(mode), .thr(thr), .busy(busy[1]),
    .gray_addr(ga1), .gray_req(greq[1]), .gray_data(gd1), .lbp_addr(la1),
    .lbp_write(lw[1]), .lbp_data(ld1), .finish(fin[1])
  );
  lbp_engine #(.IMG_W(5), .IMG_H(4), .DATA_W(8), .ADDR_W(5), .BORDER_MODE(0)) u2 (
    .clk(clk), .reset(rst[2]), .start(start[2]), .mode(mode), .thr(thr), .busy(busy[2]),
    .gray_addr(ga2), .gray_req(greq[2]), .gray_data(gd2), .lbp_addr(la2),
    .lbp_write(lw[2]), .lbp_data(ld2), .finish(fin[2])
  );

  assign la_x[0] = {2'b00, la0};
  assign la_x[1] = {2'b00, la1};
  assign la_x[2] = {3'b000, la2};
  assign ld_x[0] = ld0;
  assign ld_x[1] = ld1;
  assign ld_x[2] = ld2;

  always @(posedge clk) ec <= ec + 1;

  // Gray memory: data returned the cycle after the request
  always @(posedge clk) begin
    if (greq[0]) gd0 <= img[ga0];
    if (greq[1]) gd1 <= img[ga1];
    if (greq[2]) gd2 <= img[ga2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops on every write, plus timing statistics for the run
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      cyc = ec - run_s;
      if (greq[i]) begin
        req_cnt++;
        if (first_req < 0) first_req = cyc;
        if (cyc >= 0 && cyc < 32) req_mask[cyc] = 1'b1;
      end
      if (lw[i]) begin
        wr_cnt++;
        if (first_wr < 0) begin
          first_wr      = cyc;
          first_wr_addr = int'(la_x[i]);
        end
        last_wr = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_write_addr", {24'b0, la_x[i]}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_inst", i, {30'b0, e[17:16]});
          chk("wr_addr", {24'b0, la_x[i]}, {24'b0, e[15:8]});
          chk("wr_data", {24'b0, ld_x[i]}, {24'b0, e[7:0]});
        end
      end
      if (greq[i] && lw[i]) overlap++;
      if (busy[i]) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
        last_busy = cyc;
      end
      if (fin[i]) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    wr_cnt = 0; req_cnt = 0; fin_cnt = 0; busy_cnt = 0; overlap = 0;
    first_req = -1; first_wr = -1; last_wr = -1; fin_cyc = -1;
    first_busy = -1; last_busy = -1; first_wr_addr = -1; req_mask = '0;
  endtask

  // Reference model: push expected writes for one run
  function automatic void push_run(input int inst, input int w, input int h, input int bm,
                                   input int m, input int t);
    int dx[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int dy[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    for (int y = 1; y < h - 1; y++) begin
      for (int x = 1; x < w - 1; x++) begin
        logic [7:0] code;
        int lim;
        lim = int'(img[y * w + x]) + ((m != 0) ? t : 0);
        for (int k = 0; k < 8; k++) begin
          code[k] = (int'(img[(y + dy[k]) * w + x + dx[k]]) >= lim);
        end
        sb.push_back({2'(inst), 8'(y * w + x), code});
      end
    end
    if (bm != 0) begin
      for (int a = 0; a < w * h; a++) begin
        if ((a % w) == 0 || (a % w) == w - 1 || (a / w) == 0 || (a / w) == h - 1) begin
          sb.push_back({2'(inst), 8'(a), 8'h00});
        end
      end
    end
  endfunction

  task automatic kick(input int inst, input int m, input int t);
    clear_stats();
    mode = m[0];
    thr  = 8'(t);
    @(negedge clk);
    start[inst] = 1'b1;
    run_s = ec;
    @(negedge clk);
    start[inst] = 1'b0;
  endtask

  task automatic wait_fin(input int budget);
    for (int k = 0; k < budget && fin_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("finish_count", fin_cnt, 1);
    chk("sb_drained", sb.size(), 0);
    chk("req_wr_overlap", overlap, 0);
    sb.delete();
  endtask

  initial begin
    rst = 3'b111; start = '0; mode = 1'b0; thr = '0;
    gd0 = '0; gd1 = '0; gd2 = '0;
    clear_stats();
    for (int a = 0; a < 64; a++) img[a] = 8'(a);
    repeat (3) @(negedge clk);
    chk("rst_busy", {29'b0, busy}, 0);
    chk("rst_gray_req", {29'b0, greq}, 0);
    chk("rst_lbp_write", {29'b0, lw}, 0);
    chk("rst_finish", {29'b0, fin}, 0);
    chk("rst_gray_addr", {26'b0, ga0}, 0);
    chk("rst_lbp_addr", {26'b0, la0}, 0);
    chk("rst_lbp_data", {24'b0, ld0}, 0);
    rst = 3'b000;

    // Ramp, basic mode; a start pulse mid-run with other settings must be ignored
    kick(0, 0, 0);
    push_run(0, 8, 8, 0, 0, 0);
    repeat (40) @(negedge clk);
    mode = 1'b1; thr = 8'd200; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; mode = 1'b0; thr = 8'd0;
    wait_fin(400);
    chk("ramp_first_req", first_req, 1);
    chk("ramp_req_mask", req_mask & 32'hFFF, 32'h3FE);
    chk("ramp_req_cnt", req_cnt, 144);
    chk("ramp_wr_cnt", wr_cnt, 36);
    chk("ramp_first_wr", first_wr, 11);
    chk("ramp_last_wr", last_wr, 216);
    chk("ramp_fin_cyc", fin_cyc, 217);
    chk("ramp_first_busy", first_busy, 1);
    chk("ramp_last_busy", last_busy, 217);
    chk("ramp_busy_cnt", busy_cnt, 217);

    // Constant image, thresholded mode
    for (int a = 0; a < 64; a++) img[a] = 8'd100;
    kick(0, 1, 0);
    push_run(0, 8, 8, 0, 1, 0);
    wait_fin(400);
    chk("const_thr0_wr_cnt", wr_cnt, 36);
    kick(0, 1, 1);
    push_run(0, 8, 8, 0, 1, 1);
    wait_fin(400);

    // Saturated image: center+thr beyond 255 must not wrap
    for (int a = 0; a < 64; a++) img[a] = 8'd255;
    kick(0, 1, 5);
    push_run(0, 8, 8, 0, 1, 5);
    wait_fin(400);

    // Border fill
    for (int a = 0; a < 64; a++) img[a] = 8'(a);
    kick(1, 0, 0);
    push_run(1, 8, 8, 1, 0, 0);
    wait_fin(500);
    chk("border_wr_cnt", wr_cnt, 64);
    chk("border_last_wr", last_wr, 244);
    chk("border_fin_cyc", fin_cyc, 245);
    chk("border_req_cnt", req_cnt, 144);

    // 5x4 random image, both modes
    for (int a = 0; a < 20; a++) img[a] = 8'($urandom_range(0, 255));
    kick(2, 0, 0);
    push_run(2, 5, 4, 0, 0, 0);
    wait_fin(200);
    chk("small_req_cnt", req_cnt, 30);
    chk("small_wr_cnt", wr_cnt, 6);
    kick(2, 1, 16);
    push_run(2, 5, 4, 0, 1, 16);
    wait_fin(200);
    chk("small_thr_req_cnt", req_cnt, 30);

    // Reset one cycle after the third write aborts the run
    for (int a = 0; a < 64; a++) img[a] = 8'(a);
    kick(0, 0, 0);
    push_run(0, 8, 8, 0, 0, 0);
    for (int k = 0; k < 100 && wr_cnt < 3; k++) @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    sb.delete();
    chk("abort_wr_at_reset", wr_cnt, 3);
    repeat (300) @(negedge clk);
    chk("abort_wr_after", wr_cnt, 3);
    chk("abort_no_finish", fin_cnt, 0);
    chk("abort_idle", {31'b0, busy[0]}, 0);

    // Fresh run after the abort
    kick(0, 0, 0);
    push_run(0, 8, 8, 0, 0, 0);
    wait_fin(400);
    chk("restart_first_addr", first_wr_addr, 9);
    chk("restart_first_wr", first_wr, 11);
    chk("restart_wr_cnt", wr_cnt, 36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
